// File: rtl/mul3_stream_scheduler_if.sv
// Request/result bundle for mul3_stream_scheduler.
//   req0/data0/gnt0 : requester 0 (hold req and data until gnt pulses)
//   req1/data1/gnt1 : requester 1
//   res_valid/res_div3/res_id/res_ready : result handshake back to the consumer
// master = requesters + consumer side, slave = scheduler side.
interface mul3_stream_scheduler_if #(
  parameter int unsigned W = 16
) ();
  logic         req0;
  logic [W-1:0] data0;
  logic         gnt0;
  logic         req1;
  logic [W-1:0] data1;
  logic         gnt1;
  logic         res_valid;
  logic         res_div3;
  logic         res_id;
  logic         res_ready;

  modport master (
    output req0, data0, req1, data1, res_ready,
    input  gnt0, gnt1, res_valid, res_div3, res_id
  );

  modport slave (
    input  req0, data0, req1, data1, res_ready,
    output gnt0, gnt1, res_valid, res_div3, res_id
  );
endinterface

// File: rtl/mul3_stream_scheduler.sv
// Two-requester front end for a shared serial divisible-by-3 detector.
// A granted word is latched, the detector is held in reset while idle, the word is
// shifted in MSB-first one bit per clock, and the detector verdict on the last bit is
// returned over a valid/ready handshake. Grants alternate on ties.
// Ports:
//   clk      : system clock, rising edge
//   reset    : asynchronous active-low reset
//   bus      : request/grant and result handshake (slave modport)
//   det_x    : serial bit to the detector
//   det_rst  : detector reset, active-high (synchronous at the detector)
//   det_y    : detector verdict for the prefix including the current det_x
//   busy     : high while a word is being shifted
module mul3_stream_scheduler #(
  parameter int unsigned W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  mul3_stream_scheduler_if.slave  bus,
  output logic                    det_x,
  output logic                    det_rst,
  input  logic                    det_y,
  output logic                    busy
);

  localparam int unsigned CntW = $clog2(W);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            id_q, id_d;
  logic            last_id_q, last_id_d;
  logic            gnt0_q, gnt0_d;
  logic            gnt1_q, gnt1_d;
  logic            det_x_q, det_x_d;
  logic            det_rst_q, det_rst_d;
  logic            busy_q, busy_d;
  logic            res_valid_q, res_valid_d;
  logic            res_div3_q, res_div3_d;
  logic            res_id_q, res_id_d;
  logic            winner;

  // Lone requester wins; on a tie the one that did not own the previous result wins.
  always_comb begin
    winner = (bus.req0 && bus.req1) ? !last_id_q : !bus.req0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      cnt_q       <= '0;
      id_q        <= 1'b0;
      last_id_q   <= 1'b1;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      det_x_q     <= 1'b0;
      det_rst_q   <= 1'b1;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_div3_q  <= 1'b0;
      res_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      last_id_q   <= last_id_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      det_x_q     <= det_x_d;
      det_rst_q   <= det_rst_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_div3_q  <= res_div3_d;
      res_id_q    <= res_id_d;
    end
  end

  // Outputs are computed for the state being entered so they come straight from flops.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    last_id_d   = last_id_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    det_x_d     = 1'b0;
    det_rst_d   = det_rst_q;
    busy_d      = 1'b0;
    res_valid_d = res_valid_q;
    res_div3_d  = res_div3_q;
    res_id_d    = res_id_q;

    unique case (state_q)
      StIdle: begin
        det_rst_d = 1'b1;
        if (bus.req0 || bus.req1) begin
          shreg_d   = winner ? bus.data1 : bus.data0;
          cnt_d     = CntW'(W - 1);
          id_d      = winner;
          gnt0_d    = !winner;
          gnt1_d    = winner;
          det_x_d   = winner ? bus.data1[W-1] : bus.data0[W-1];
          det_rst_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = StShift;
        end
      end

      StShift: begin
        det_rst_d = 1'b0;
        shreg_d   = {shreg_q[W-2:0], 1'b0};
        if (cnt_q == '0) begin
          // det_y now reflects the whole word.
          res_div3_d  = det_y;
          res_id_d    = id_q;
          res_valid_d = 1'b1;
          last_id_d   = id_q;
          state_d     = StDone;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          det_x_d = shreg_q[W-2];
          busy_d  = 1'b1;
        end
      end

      StDone: begin
        det_rst_d = 1'b0;
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          det_rst_d   = 1'b1;
          state_d     = StIdle;
        end
      end

      default: begin
        det_rst_d   = 1'b1;
        res_valid_d = 1'b0;
        state_d     = StIdle;
      end
    endcase
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_div3  = res_div3_q;
  assign bus.res_id    = res_id_q;
  assign det_x         = det_x_q;
  assign det_rst       = det_rst_q;
  assign busy          = busy_q;

endmodule
